mix_columns_enc: RTL and testbench

Sequential AES forward MixColumns engine for the encryption datapath, the counterpart of the decryption-side InvMixColumns multiply lookups. It accepts a 128-bit AES state through a valid/ready handshake and transforms one 32-bit column per cycle using GF(2^8) xtime logic. It returns the result through a valid/ready handshake. A bypass input passes the state through unchanged, for the final AES round, with identical latency.

---
 rtl/mix_columns_enc_if.sv | 21 ++
 rtl/mix_columns_enc.sv | 96 +++++++++
 tb/tb_mix_columns_enc.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mix_columns_enc_if.sv
// rtl/mix_columns_enc_if.sv - state-in / state-out handshake bundle for the MixColumns engine
interface mix_columns_enc_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport master (
    output in_valid, in_state, in_bypass, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, in_bypass, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/mix_columns_enc.sv
// rtl/mix_columns_enc.sv - column-serial AES forward MixColumns with final-round bypass
module mix_columns_enc (
  input  logic              clk,
  input  logic              rst,
  mix_columns_enc_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t       state;
  logic [1:0]   col;
  logic [127:0] w;
  logic         bypass_q;
  logic [31:0]  cur_col;
  logic [31:0]  mixed_col;
  logic         accept;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Row 0 of a column sits in the most significant byte.
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    d0 = xtime(a0);
    d1 = xtime(a1);
    d2 = xtime(a2);
    d3 = xtime(a3);
    return {d0 ^ d1 ^ a1 ^ a2 ^ a3,
            a0 ^ d1 ^ d2 ^ a2 ^ a3,
            a0 ^ a1 ^ d2 ^ d3 ^ a3,
            d0 ^ a0 ^ a1 ^ a2 ^ d3};
  endfunction

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_state = w;
  assign accept        = bus.in_valid && bus.in_ready;

  always_comb begin
    cur_col = '0;
    for (int c = 0; c < 4; c++) begin
      if (col == 2'(c)) cur_col = w[127-32*c -: 32];
    end
  end

  assign mixed_col = mix_column(cur_col);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      col      <= 2'd0;
      w        <= '0;
      bypass_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            w        <= bus.in_state;
            bypass_q <= bus.in_bypass;
            col      <= 2'd0;
            state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (!bypass_q) begin
            for (int c = 0; c < 4; c++) begin
              if (col == 2'(c)) w[127-32*c -: 32] <= mixed_col;
            end
          end
          col <= col + 2'd1;
          if (col == 2'd3) state <= DONE;
        end
        DONE: begin
          // A waiting upstream state is taken on the same edge the result leaves.
          if (bus.out_ready) begin
            if (bus.in_valid) begin
              w        <= bus.in_state;
              bypass_q <= bus.in_bypass;
              col      <= 2'd0;
              state    <= COMPUTE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mix_columns_enc.sv
// tb/tb_mix_columns_enc.sv - directed and randomized checks of mix_columns_enc against a GF(2^8) matrix model
module tb_mix_columns_enc;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  mix_columns_enc_if bus ();

  mix_columns_enc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full carry-less product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] prod;
    logic [14:0] poly;
    prod = '0;
    poly = 15'h11b;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (poly << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic byp);
    logic [7:0]   base [4];
    logic [7:0]   a    [4];
    logic [7:0]   acc;
    logic [127:0] r;
    base[0] = 8'd2; base[1] = 8'd3; base[2] = 8'd1; base[3] = 8'd1;
    r = s;
    if (!byp) begin
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
        for (int row = 0; row < 4; row++) begin
          acc = 8'h00;
          for (int k = 0; k < 4; k++) acc = acc ^ gmul(a[k], base[(k - row + 4) % 4]);
          r[127-32*c-8*row -: 8] = acc;
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic offer(input logic [127:0] s, input logic b);
    int n;
    n = 0;
    bus.in_valid  = 1'b1;
    bus.in_state  = s;
    bus.in_bypass = b;
    #1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept", 128'(bus.in_ready), 128'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [127:0] exp);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk({tag, "_early_valid"}, 128'(bus.out_valid), 128'd0);
    end
    @(negedge clk);
    chk({tag, "_valid"}, 128'(bus.out_valid), 128'd1);
    chk({tag, "_state"}, bus.out_state, exp);
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] s, s2, hold_val, exp_v;
    logic         byp, pend, seen;
    logic [127:0] expq [$];
    int           sent, got, cyc;

    total = 0;
    bad   = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready",  128'(bus.in_ready),  128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_state", bus.out_state,       128'h0);
    chk("rst_busy",      128'(bus.busy),      128'd0);

    offer(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0);
    chk("fips_busy", 128'(bus.busy), 128'd1);
    expect_result("fips", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    retire();

    offer(128'hd4d4d4d5_2d26314c_01010101_01010101, 1'b0);
    expect_result("cols", 128'hd5d5d7d6_4d7ebdf8_01010101_01010101);
    retire();

    offer(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1);
    expect_result("bypass", 128'h00112233_44556677_8899aabb_ccddeeff);
    retire();
    chk("idle_again", 128'(bus.busy), 128'd0);

    s  = {$urandom, $urandom, $urandom, $urandom};
    s2 = {$urandom, $urandom, $urandom, $urandom};
    offer(s, 1'b0);
    expect_result("bp_first", model(s, 1'b0));
    hold_val = model(s, 1'b0);
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = k[0];
      bus.in_state = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("bp_hold_state", bus.out_state,        hold_val);
      chk("bp_hold_valid", 128'(bus.out_valid),  128'd1);
      chk("bp_in_ready",   128'(bus.in_ready),   128'd0);
    end
    bus.in_valid  = 1'b1;
    bus.in_state  = s2;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_busy", 128'(bus.busy), 128'd1);
    expect_result("b2b_second", model(s2, 1'b0));
    retire();

    offer({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready",  128'(bus.in_ready),  128'd1);
    chk("midrst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("midrst_out_state", bus.out_state,       128'h0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", 128'(seen), 128'd0);

    sent = 0;
    got  = 0;
    cyc  = 0;
    pend = 1'b0;
    while ((sent < 1000 || got < 1000) && cyc < 40000) begin
      @(negedge clk);
      if (!pend && sent < 1000 && $urandom_range(0, 9) < 6) begin
        bus.in_state  = {$urandom, $urandom, $urandom, $urandom};
        bus.in_bypass = ($urandom_range(0, 7) == 0);
        bus.in_valid  = 1'b1;
        pend = 1'b1;
      end else if (!pend) begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          chk("stream_unexpected", 128'(bus.out_valid), 128'd0);
        end else begin
          exp_v = expq.pop_front();
          chk("stream_data", bus.out_state, exp_v);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        s   = bus.in_state;
        byp = bus.in_bypass;
        expq.push_back(model(s, byp));
        sent++;
        pend = 1'b0;
      end
      cyc++;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("stream_sent",    128'(sent),        128'd1000);
    chk("stream_got",     128'(got),         128'd1000);
    chk("stream_leftover", 128'(expq.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
